// File: rtl/pipeline_ctrl.sv
// Control and hazard unit for the 16-bit five-stage pipelined datapath.
// Optional BANK_SWITCH_EN enables the BANK opcode and banked register reads.
module pipeline_ctrl #(
   parameter logic [3:0] NOP_OP = 4'hF,
   parameter logic [3:0] LD_OP  = 4'h6,
   parameter logic [3:0] ST_OP  = 4'h7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       alu_z,
   input  logic [3:0] rr1,
   input  logic [3:0] rr2,
   input  logic [3:0] wr_exe,
   input  logic [3:0] wr_mem,
   output logic       pc_src,
   output logic       stall_ld,
   output logic       stall_jmp,
   output logic       stall_dummy,
   output logic       bank_en,
   output logic       rr1_src,
   output logic       rr2_src,
   output logic       wr_src,
   output logic       format_sel,
   output logic [1:0] dr1_src,
   output logic [1:0] dr2_src,
   output logic       alu_src,
   output logic [3:0] alu_op,
   output logic       mem_we,
   output logic       rfile_we,
   output logic       wd_src
);

`ifdef BANK_SWITCH_EN
   localparam logic BANKED = 1'b1;
`else
   localparam logic BANKED = 1'b0;
`endif

   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_BEQZ = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_BANK = 4'hE;

   typedef struct packed {
      logic       writes;
      logic       is_ld;
      logic       is_st;
      logic       is_br;
      logic       is_bank;
      logic       alu_src;
      logic [3:0] alu_op;
   } dec_t;

   localparam dec_t BUBBLE = '0;

   dec_t       p_ctl;
   dec_t       d_q;
   logic       p_jmp;
   logic       use1;
   logic       use2;

   logic       e_writes, e_ld, e_st, e_br, e_alu_src;
   logic [3:0] e_alu_op;
   logic       m_writes, m_ld, m_st;
   logic       w_writes, w_ld;

   logic [1:0] sq_cnt;
   logic       jmp_sq;
   logic       br_taken;
   logic       dec_dead;
   logic       pre_dead;
   logic       jmp_go;
   logic       load_use;

   // Predecode: pure function of the opcode now sitting in IR.
   always_comb begin
      p_ctl      = BUBBLE;
      p_jmp      = 1'b0;
      use1       = 1'b0;
      use2       = 1'b0;
      wr_src     = 1'b0;
      format_sel = 1'b0;
      unique case (1'b1)
         (opcode <= 4'h4): begin
            p_ctl.writes = 1'b1;
            p_ctl.alu_op = opcode;
            use1 = 1'b1;
            use2 = 1'b1;
         end
         (opcode == OP_ADDI): begin
            p_ctl.writes  = 1'b1;
            p_ctl.alu_src = 1'b1;
            wr_src = 1'b1;
            use1   = 1'b1;
         end
         (opcode == LD_OP): begin
            p_ctl.writes  = 1'b1;
            p_ctl.is_ld   = 1'b1;
            p_ctl.alu_src = 1'b1;
            wr_src = 1'b1;
            use1   = 1'b1;
         end
         (opcode == ST_OP): begin
            p_ctl.is_st   = 1'b1;
            p_ctl.alu_src = 1'b1;
            use1 = 1'b1;
            use2 = 1'b1;
         end
         (opcode == OP_BEQZ): begin
            p_ctl.is_br = 1'b1;
            use1 = 1'b1;
         end
         (opcode == OP_JMP): begin
            p_jmp      = 1'b1;
            format_sel = 1'b1;
         end
         (opcode == OP_BANK): p_ctl.is_bank = BANKED;
         (opcode == NOP_OP): ;
         default: ;
      endcase
   end

   assign rr1_src = BANKED & use1;
   assign rr2_src = BANKED & use2;

   // Squash counter covers the two wrong-path slots behind a taken branch
   // plus the one fetched while the redirect was being issued.
   assign br_taken = e_br & alu_z;
   assign dec_dead = br_taken | (sq_cnt != 2'd0);
   assign pre_dead = jmp_sq | br_taken | (sq_cnt == 2'd2);
   assign jmp_go   = p_jmp & ~pre_dead;
   assign pc_src   = br_taken | jmp_go;

   assign load_use = e_ld & ~dec_dead &
                     ((rr1 == wr_exe) | (rr2 == wr_exe));

   assign stall_ld    = ~load_use;
   assign stall_jmp   = ~load_use;
   assign stall_dummy = 1'b1;
   assign bank_en     = d_q.is_bank & ~dec_dead & ~load_use;

   function automatic logic [1:0] fwd(
      input logic [3:0] rr,
      input logic       ew,
      input logic       el,
      input logic [3:0] we,
      input logic       mw,
      input logic       ml,
      input logic [3:0] wm
   );
      if (ew && !el && rr == we)
         return 2'd1;
      else if (mw && rr == wm)
         return ml ? 2'd3 : 2'd0;
      else
         return 2'd2;
   endfunction

   always_comb begin
      dr1_src = fwd(rr1, e_writes, e_ld, wr_exe, m_writes, m_ld, wr_mem);
      dr2_src = fwd(rr2, e_writes, e_ld, wr_exe, m_writes, m_ld, wr_mem);
   end

   assign alu_op   = e_alu_op;
   assign alu_src  = e_alu_src;
   assign mem_we   = m_st;
   assign rfile_we = w_writes;
   assign wd_src   = w_ld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_q       <= BUBBLE;
         jmp_sq    <= 1'b0;
         sq_cnt    <= 2'd0;
         e_writes  <= 1'b0;
         e_ld      <= 1'b0;
         e_st      <= 1'b0;
         e_br      <= 1'b0;
         e_alu_src <= 1'b0;
         e_alu_op  <= 4'h0;
         m_writes  <= 1'b0;
         m_ld      <= 1'b0;
         m_st      <= 1'b0;
         w_writes  <= 1'b0;
         w_ld      <= 1'b0;
      end else begin
         if (stall_ld) begin
            d_q    <= pre_dead ? BUBBLE : p_ctl;
            jmp_sq <= jmp_go;
         end

         if (br_taken)
            sq_cnt <= 2'd2;
         else if (sq_cnt != 2'd0)
            sq_cnt <= sq_cnt - 2'd1;

         if (dec_dead || load_use) begin
            e_writes  <= 1'b0;
            e_ld      <= 1'b0;
            e_st      <= 1'b0;
            e_br      <= 1'b0;
            e_alu_src <= 1'b0;
            e_alu_op  <= 4'h0;
         end else begin
            e_writes  <= d_q.writes;
            e_ld      <= d_q.is_ld;
            e_st      <= d_q.is_st;
            e_br      <= d_q.is_br;
            e_alu_src <= d_q.alu_src;
            e_alu_op  <= d_q.alu_op;
         end

         m_writes <= e_writes;
         m_ld     <= e_ld;
         m_st     <= e_st;
         w_writes <= m_writes;
         w_ld     <= m_ld;
      end
   end

endmodule
